// File: rtl/idu_pkg.sv
// Shared decode definitions for the instruction decode stage.
// Optional build macro: IDU_RVE_EN (16-register RV32E decode; register fields with bit 4 set are
// illegal).
package idu_pkg;

  typedef enum logic [3:0] {
    OcLui     = 4'd0,
    OcAuipc   = 4'd1,
    OcJal     = 4'd2,
    OcJalr    = 4'd3,
    OcBranch  = 4'd4,
    OcLoad    = 4'd5,
    OcStore   = 4'd6,
    OcOpImm   = 4'd7,
    OcOp      = 4'd8,
    OcFence   = 4'd9,
    OcSystem  = 4'd10,
    OcIllegal = 4'd15
  } opclass_e;

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcFence  = 7'b0001111;
  localparam logic [6:0] OpcSystem = 7'b1110011;

  localparam logic [31:0] FENCE_I_INST = 32'h0000_100F;

  typedef struct packed {
    opclass_e    opclass;
    logic [31:0] imm;
    logic        rf_wen;
    logic        fence_i;
    logic        illegal;
  } dec_t;

  // Source-register usage {rs2, rs1}; only CSR register forms of SYSTEM read rs1.
  function automatic logic [1:0] idu_src_use(logic [31:0] inst);
    logic [1:0] u;
    case (inst[6:0])
      OpcJalr, OpcLoad, OpcOpImm: u = 2'b01;
      OpcBranch, OpcStore, OpcOp: u = 2'b11;
      OpcSystem:                  u = {1'b0, (inst[14:12] != 3'b000) && !inst[14]};
      default:                    u = 2'b00;
    endcase
    return u;
  endfunction

  function automatic dec_t idu_decode(logic [31:0] inst);
    dec_t        d;
    logic        uses_rd;
    logic [1:0]  src;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    imm_i = {{20{inst[31]}}, inst[31:20]};
    imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    imm_u = {inst[31:12], 12'b0};
    imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    src   = idu_src_use(inst);
    d         = '0;
    d.illegal = 1'b0;
    uses_rd   = 1'b0;
    case (inst[6:0])
      OpcLui:    begin d.opclass = OcLui;    d.imm = imm_u; uses_rd = 1'b1; end
      OpcAuipc:  begin d.opclass = OcAuipc;  d.imm = imm_u; uses_rd = 1'b1; end
      OpcJal:    begin d.opclass = OcJal;    d.imm = imm_j; uses_rd = 1'b1; end
      OpcJalr:   begin d.opclass = OcJalr;   d.imm = imm_i; uses_rd = 1'b1; end
      OpcBranch: begin d.opclass = OcBranch; d.imm = imm_b; end
      OpcLoad:   begin d.opclass = OcLoad;   d.imm = imm_i; uses_rd = 1'b1; end
      OpcStore:  begin d.opclass = OcStore;  d.imm = imm_s; end
      OpcOpImm:  begin d.opclass = OcOpImm;  d.imm = imm_i; uses_rd = 1'b1; end
      OpcOp:     begin d.opclass = OcOp;     d.imm = '0;    uses_rd = 1'b1; end
      OpcFence:  begin d.opclass = OcFence;  d.imm = imm_i; end
      OpcSystem: begin
        d.opclass = OcSystem;
        d.imm     = imm_i;
        uses_rd   = (inst[14:12] != 3'b000);
      end
      default:   begin d.opclass = OcIllegal; d.imm = '0; d.illegal = 1'b1; end
    endcase
`ifdef IDU_RVE_EN
    if ((src[0] && inst[19]) || (src[1] && inst[24]) || (uses_rd && inst[11])) begin
      d.illegal = 1'b1;
      uses_rd   = 1'b0;
    end
`else
    src = '0;
`endif
    d.rf_wen  = uses_rd && (inst[11:7] != 5'd0);
    d.fence_i = (inst == FENCE_I_INST);
    return d;
  endfunction

endpackage

// File: rtl/idu_scoreboard.sv
// Per-register pending-write counters; busy flags reflect registered state only, so a retire
// pulse becomes visible one cycle later.
module idu_scoreboard #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned SB_W  = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inc_i,
  input  logic [4:0] inc_rd_i,
  input  logic       dec_i,
  input  logic [4:0] dec_rd_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  output logic       rs1_busy_o,
  output logic       rs2_busy_o
);

  localparam int unsigned IdxW = $clog2(NREGS);

  logic [SB_W-1:0] cnt_q [NREGS];
  logic [SB_W-1:0] cnt_d [NREGS];

  // Counter update; x0 never counts and a same-cycle inc/dec pair cancels.
  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r != 0) begin
        if (inc_i && (inc_rd_i == 5'(r)) && !(dec_i && (dec_rd_i == 5'(r)))) begin
          cnt_d[r] = cnt_q[r] + SB_W'(1);
        end else if (dec_i && (dec_rd_i == 5'(r)) && !(inc_i && (inc_rd_i == 5'(r)))) begin
          cnt_d[r] = cnt_q[r] - SB_W'(1);
        end
      end
    end
  end

  // Counter state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < NREGS; r++) cnt_q[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  // Wrap in either direction means the one-retire-per-write contract was broken.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned r = 1; r < NREGS; r++) begin
        if (inc_i && (inc_rd_i == 5'(r)) && !(dec_i && (dec_rd_i == 5'(r))))
          assert (cnt_q[r] != {SB_W{1'b1}});
        if (dec_i && (dec_rd_i == 5'(r)) && !(inc_i && (inc_rd_i == 5'(r))))
          assert (cnt_q[r] != '0);
      end
    end
  end

  assign rs1_busy_o = (32'(rs1_i) < NREGS) && (cnt_q[rs1_i[IdxW-1:0]] != '0);
  assign rs2_busy_o = (32'(rs2_i) < NREGS) && (cnt_q[rs2_i[IdxW-1:0]] != '0);

endmodule

// File: rtl/idu_decode_stage.sv
// Decode stage: single output register, combinational decode of the held instruction and
// RAW-hazard stall against the scoreboard and the held destination.
// Optional build macro: IDU_RVE_EN (16 registers, high register fields illegal).
module idu_decode_stage
  import idu_pkg::*;
#(
`ifdef IDU_RVE_EN
  parameter int unsigned NREGS = 16,
`else
  parameter int unsigned NREGS = 32,
`endif
  parameter int unsigned SB_W = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_valid,
  output logic        ifu_ready,
  input  logic [31:0] ifu_pc,
  input  logic [31:0] ifu_inst,
  input  logic [63:0] ifu_num,
  input  logic        control_hazard,
  output logic        exu_valid,
  input  logic        exu_ready,
  output logic [31:0] exu_pc,
  output logic [31:0] exu_inst,
  output logic [63:0] exu_num,
  output logic [4:0]  exu_rs1,
  output logic [4:0]  exu_rs2,
  output logic [4:0]  exu_rd,
  output logic [31:0] exu_imm,
  output logic [3:0]  exu_opclass,
  output logic [2:0]  exu_funct3,
  output logic        exu_funct7b5,
  output logic        exu_rf_wen,
  output logic        exu_fence_i,
  output logic        exu_illegal,
  input  logic        wbu_clr,
  input  logic [4:0]  wbu_clr_rd
);

`ifdef IDU_RVE_EN
  localparam int unsigned NRegsEff = 16;
`else
  localparam int unsigned NRegsEff = NREGS;
`endif

  logic        out_valid_q, out_valid_d;
  logic [31:0] pc_q, inst_q;
  logic [63:0] num_q;
  dec_t        held_dec;
  logic [1:0]  in_use;
  logic        rs1_busy, rs2_busy, rs1_haz, rs2_haz, hazard, held_wr;
  logic        accept, exu_fire;

  assign held_dec = idu_decode(inst_q);
  assign in_use   = idu_src_use(ifu_inst);
  assign held_wr  = out_valid_q && held_dec.rf_wen;

  idu_scoreboard #(
    .NREGS (NRegsEff),
    .SB_W  (SB_W)
  ) u_scoreboard (
    .clock      (clock),
    .reset      (reset),
    .inc_i      (exu_fire && held_dec.rf_wen),
    .inc_rd_i   (inst_q[11:7]),
    .dec_i      (wbu_clr),
    .dec_rd_i   (wbu_clr_rd),
    .rs1_i      (ifu_inst[19:15]),
    .rs2_i      (ifu_inst[24:20]),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy)
  );

  // The held instruction is not yet counted, so its rd is checked directly.
  assign rs1_haz = in_use[0] && (ifu_inst[19:15] != 5'd0) &&
                   (rs1_busy || (held_wr && (inst_q[11:7] == ifu_inst[19:15])));
  assign rs2_haz = in_use[1] && (ifu_inst[24:20] != 5'd0) &&
                   (rs2_busy || (held_wr && (inst_q[11:7] == ifu_inst[24:20])));
  assign hazard  = rs1_haz || rs2_haz;

  assign ifu_ready = (!out_valid_q || exu_ready) && !hazard && !control_hazard;
  assign exu_valid = out_valid_q && !control_hazard;
  assign accept    = ifu_valid && ifu_ready;
  assign exu_fire  = exu_valid && exu_ready;

  // Valid-bit next state; a flush wins over everything.
  always_comb begin
    out_valid_d = out_valid_q;
    if (control_hazard) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
    end else if (exu_fire) begin
      out_valid_d = 1'b0;
    end
  end

  // Output pipeline register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      inst_q      <= '0;
      num_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept) begin
        pc_q   <= ifu_pc;
        inst_q <= ifu_inst;
        num_q  <= ifu_num;
      end
    end
  end

  assign exu_pc       = pc_q;
  assign exu_inst     = inst_q;
  assign exu_num      = num_q;
  assign exu_rs1      = inst_q[19:15];
  assign exu_rs2      = inst_q[24:20];
  assign exu_rd       = inst_q[11:7];
  assign exu_funct3   = inst_q[14:12];
  assign exu_funct7b5 = inst_q[30];
  assign exu_imm      = held_dec.imm;
  assign exu_opclass  = held_dec.opclass;
  assign exu_rf_wen   = held_dec.rf_wen;
  assign exu_fence_i  = held_dec.fence_i;
  assign exu_illegal  = held_dec.illegal;

endmodule

// File: doc/idu_decode_stage.md
# idu_decode_stage

Instruction decode stage between the instruction fetch unit and the execute unit. It accepts one fetched instruction per handshake, holds it in a single output pipeline register, decodes it into a control bundle, and stalls on read-after-write hazards using a per-register pending-write scoreboard. It discards its held instruction when the pipeline is redirected by a control hazard.

## Interface
Parameters:
- `NREGS`, default 32: architectural register count; forced to 16 when `IDU_RVE_EN` is defined.
- `SB_W`, default 3: width of each scoreboard counter.

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low.
- `ifu_valid` in 1: fetch output is valid.
- `ifu_ready` out 1: decode stage accepts an instruction this cycle.
- `ifu_pc` in 32: PC of the fetched instruction.
- `ifu_inst` in 32: fetched instruction word.
- `ifu_num` in 64: instruction sequence number.
- `control_hazard` in 1: redirect/flush request.
- `exu_valid` out 1: decoded bundle is valid.
- `exu_ready` in 1: execute unit accepts the bundle.
- `exu_pc` out 32, `exu_inst` out 32, `exu_num` out 64: held copies of the accepted instruction.
- `exu_rs1`, `exu_rs2`, `exu_rd` out 5 each: register fields.
- `exu_imm` out 32: sign-extended immediate.
- `exu_opclass` out 4: decoded class.
- `exu_funct3` out 3, `exu_funct7b5` out 1: ALU sub-op fields.
- `exu_rf_wen` out 1: writes `rd`; `rd==0` forces 0.
- `exu_fence_i` out 1: instruction is `0x0000100F`.
- `exu_illegal` out 1: opcode not decodable.
- `wbu_clr` in 1: writeback retire pulse.
- `wbu_clr_rd` in 5: register retired by `wbu_clr`.

## Operation
- Output register holds `out_valid` plus the fields latched from the IFU; the decode logic is combinational from the held `exu_inst`.
- `exu_opclass` encodings: LUI=0, AUIPC=1, JAL=2, JALR=3, BRANCH=4, LOAD=5, STORE=6, OPIMM=7, OP=8, FENCE=9, SYSTEM=10, ILLEGAL=15.
- Immediate formats: I, S, B, U, J, each sign-extended from instruction bit 31; R-type gives 0.
- For S and B types, `exu_rf_wen`=0.
- Scoreboard: one `SB_W`-bit counter per register.
  - Increments on an EXU handshake (`exu_valid && exu_ready && exu_rf_wen`).
  - Decrements on `wbu_clr` for `wbu_clr_rd`.
  - An increment and a decrement on the same register in the same cycle leave it unchanged.
  - Register x0 is never counted.
- Hazard on the incoming `ifu_inst` when rs1 or rs2 (only those the format uses, and non-zero):
  - has a non-zero counter, or
  - equals the held `rd` while `out_valid && exu_rf_wen`.
- The scoreboard ignores a `wbu_clr` arriving in the same cycle; a stalled instruction waits one more cycle.
- `ifu_ready = (!out_valid || exu_ready) && !hazard && !control_hazard`.
- `exu_valid = out_valid && !control_hazard`.
- On `control_hazard`, `out_valid` clears at the next edge. No handshake occurs in that cycle on either side, and the scoreboard is not incremented.
- Contract with downstream: every issued instruction with `exu_rf_wen` produces exactly one `wbu_clr`, including instructions squashed downstream.
- Counter overflow or underflow is a simulation assertion failure.

## Timing
- Reset values: `out_valid`=0, all counters=0, all held fields=0. Consequently `exu_valid`=0, `exu_opclass`=ILLEGAL, `exu_imm`=0, and `ifu_ready`=1 once `control_hazard`=0.
- Latency: an instruction accepted at edge N presents `exu_valid`=1 after edge N.
- Full throughput is one instruction per cycle when `exu_ready` stays high and there is no hazard.
- Back-pressure: while `exu_valid && !exu_ready`, all `exu_*` outputs hold stable.
- Reset asserted mid-operation clears state immediately (asynchronously); in-flight fields are lost.

## Configuration
- `IDU_RVE_EN` defined:
  - `NREGS`=16.
  - Any used rs1, rs2 or rd field with bit 4 set raises `exu_illegal` and forces `exu_rf_wen`=0.
  - The scoreboard has 16 counters.
- `IDU_RVE_EN` undefined: 32 registers; register fields are never illegal.

## Structure
- Shared package `idu_pkg`:
  - opclass enum;
  - opcode constants;
  - `FENCE_I_INST`;
  - decoded bundle struct.
- Sub-module `idu_scoreboard`:
  - inputs: `clock`, `reset`, increment, decrement, and query rs1/rs2;
  - outputs: busy flags.
- Decode and hazard comparison remain in the top module.

## Test plan
- Reset released, `ifu_valid`=1, `ifu_inst`=0x00500093 (addi x1,x0,5), `exu_ready`=1 -> next cycle `exu_valid`=1, `exu_rd`=1, `exu_imm`=5, `exu_opclass`=7, `exu_rf_wen`=1.
- addi x1 issued, then `ifu_inst`=0x00108133 (add x2,x1,x1) -> `ifu_ready`=0 until `wbu_clr` with `wbu_clr_rd`=1, then accepted one cycle after the pulse.
- `exu_ready`=0 for 5 cycles with a bundle held -> all `exu_*` outputs stable and `ifu_ready`=0; `exu_ready`=1 -> handshake, and the next instruction is accepted in the same cycle.
- `control_hazard`=1 while holding `rd`=3 -> `exu_valid`=0 that cycle, `out_valid`=0 after the edge, counter for x3 remains 0.
- `ifu_inst`=0x0000100F -> `exu_fence_i`=1, `exu_opclass`=9; `ifu_inst`=0xFFFFFFFF -> `exu_illegal`=1, `exu_rf_wen`=0.
- With `IDU_RVE_EN` defined, `ifu_inst`=0x01000893 (addi x17,x0,16) -> `exu_illegal`=1, `exu_rf_wen`=0, scoreboard unchanged after the handshake.
